// File: rtl/oled_frame_sequencer_if.sv
// ============================================================================
// oled_frame_sequencer_if : image-source / byte-transmitter signal bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface oled_frame_sequencer_if;
    logic       frame_req;
    logic [7:0] pixel_data;
    logic       tx_ready;
    logic [9:0] byte_counter;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_valid;
    logic       busy;
    logic       frame_done;

    modport master (
        input  frame_req, pixel_data, tx_ready,
        output byte_counter, tx_data, tx_dc, tx_valid, busy, frame_done
    );

    modport slave (
        output frame_req, pixel_data, tx_ready,
        input  byte_counter, tx_data, tx_dc, tx_valid, busy, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/oled_frame_sequencer.sv
// ============================================================================
// oled_frame_sequencer : SSD1306 init/window/frame byte sequencer
// Optional panel init list built when OLED_INIT_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_frame_sequencer #(
    parameter int FRAME_BYTES    = 1024,
    parameter int REFRESH_CYCLES = 2500000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    oled_frame_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_SEND = 3'd5;
`ifdef OLED_INIT_EN
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_RESET = S_INIT;
`else
    localparam logic [2:0] S_RESET = S_IDLE;
`endif

    localparam int             RW        = $clog2(REFRESH_CYCLES);
    localparam logic [RW-1:0]  REF_LAST  = RW'(REFRESH_CYCLES - 1);
    localparam logic [9:0]     LAST_BYTE = 10'(FRAME_BYTES - 1);
    localparam logic [4:0]     ADDR_LAST = 5'd5;

`ifdef OLED_INIT_EN
    localparam logic [4:0]     INIT_LAST = 5'd24;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    return 8'hAE;
            5'd1:    return 8'hD5;
            5'd2:    return 8'h80;
            5'd3:    return 8'hA8;
            5'd4:    return 8'h3F;
            5'd5:    return 8'hD3;
            5'd6:    return 8'h00;
            5'd7:    return 8'h40;
            5'd8:    return 8'h8D;
            5'd9:    return 8'h14;
            5'd10:   return 8'h20;
            5'd11:   return 8'h00;
            5'd12:   return 8'hA1;
            5'd13:   return 8'hC8;
            5'd14:   return 8'hDA;
            5'd15:   return 8'h12;
            5'd16:   return 8'h81;
            5'd17:   return 8'hCF;
            5'd18:   return 8'hD9;
            5'd19:   return 8'hF1;
            5'd20:   return 8'hDB;
            5'd21:   return 8'h40;
            5'd22:   return 8'hA4;
            5'd23:   return 8'hA6;
            default: return 8'hAF;
        endcase
    endfunction
`endif

    // Column range 0..127, page range 0..7: the whole panel.
    function automatic logic [7:0] addr_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h21;
            3'd1:    return 8'h00;
            3'd2:    return 8'h7F;
            3'd3:    return 8'h22;
            3'd4:    return 8'h00;
            default: return 8'h07;
        endcase
    endfunction

    logic [2:0]    state_q, state_d;
    logic [9:0]    byte_counter_q, byte_counter_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_dc_q, tx_dc_d;
    logic          tx_valid_q, tx_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          pending_q, pending_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [4:0]    cmd_idx_q, cmd_idx_d;

    logic accept;
    logic tick;

    assign accept = tx_valid_q && bus.tx_ready;
    assign tick   = (ref_cnt_q == REF_LAST);

    always_comb begin
        state_d        = state_q;
        byte_counter_d = byte_counter_q;
        tx_data_d      = tx_data_q;
        tx_dc_d        = tx_dc_q;
        tx_valid_d     = tx_valid_q;
        frame_done_d   = 1'b0;
        cmd_idx_d      = cmd_idx_q;
        ref_cnt_d      = tick ? '0 : ref_cnt_q + RW'(1);

        // The clear in IDLE comes first so a same-cycle request re-arms it.
        pending_d = pending_q;
        if ((state_q == S_IDLE) && pending_q) begin
            pending_d = 1'b0;
        end
        if (tick || bus.frame_req) begin
            pending_d = 1'b1;
        end

        case (state_q)
`ifdef OLED_INIT_EN
            S_INIT: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_dc_d    = 1'b0;
                    tx_data_d  = init_rom(cmd_idx_q);
                end else if (accept) begin
                    if (cmd_idx_q == INIT_LAST) begin
                        tx_valid_d = 1'b0;
                        cmd_idx_d  = '0;
                        state_d    = S_IDLE;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 5'd1;
                        tx_data_d = init_rom(cmd_idx_q + 5'd1);
                    end
                end
            end
`endif
            S_IDLE: begin
                if (pending_q) begin
                    tx_valid_d = 1'b1;
                    tx_dc_d    = 1'b0;
                    tx_data_d  = addr_rom(3'd0);
                    cmd_idx_d  = '0;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (accept) begin
                    if (cmd_idx_q == ADDR_LAST) begin
                        tx_valid_d     = 1'b0;
                        cmd_idx_d      = '0;
                        byte_counter_d = '0;
                        state_d        = S_LOAD;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 5'd1;
                        tx_data_d = addr_rom(cmd_idx_q[2:0] + 3'd1);
                    end
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tx_data_d  = bus.pixel_data;
                tx_dc_d    = 1'b1;
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    if (byte_counter_q < LAST_BYTE) begin
                        byte_counter_d = byte_counter_q + 10'd1;
                        state_d        = S_LOAD;
                    end else begin
                        byte_counter_d = '0;
                        frame_done_d   = 1'b1;
                        state_d        = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_RESET;
            byte_counter_q <= '0;
            tx_data_q      <= '0;
            tx_dc_q        <= 1'b0;
            tx_valid_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            pending_q      <= 1'b0;
            ref_cnt_q      <= '0;
            cmd_idx_q      <= '0;
        end else begin
            state_q        <= state_d;
            byte_counter_q <= byte_counter_d;
            tx_data_q      <= tx_data_d;
            tx_dc_q        <= tx_dc_d;
            tx_valid_q     <= tx_valid_d;
            frame_done_q   <= frame_done_d;
            pending_q      <= pending_d;
            ref_cnt_q      <= ref_cnt_d;
            cmd_idx_q      <= cmd_idx_d;
        end
    end

    assign bus.byte_counter = byte_counter_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_dc        = tx_dc_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_oled_frame_sequencer.sv
// ============================================================================
// tb_oled_frame_sequencer : scoreboard bench for oled_frame_sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oled_frame_sequencer;

    localparam int FB  = 1024;
    localparam int FB2 = 2;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
        logic       chk_idx;
        logic [9:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst2;

    always #5 clk = ~clk;

    oled_frame_sequencer_if bus();
    oled_frame_sequencer_if bus2();

    oled_frame_sequencer #(.FRAME_BYTES(FB), .REFRESH_CYCLES(1000000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    oled_frame_sequencer #(.FRAME_BYTES(FB2), .REFRESH_CYCLES(100)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done2_cnt = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;
    logic done_busy = 1'b0;
    logic done_prev = 1'b0;
    logic busy_prev = 1'b0;
    logic stall_prev = 1'b0;
    logic [7:0] st_data;
    logic       st_dc;
    logic [9:0] st_bc;
    exp_t sb[$];

    logic [7:0] addr_list [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
`ifdef OLED_INIT_EN
    logic [7:0] init_list [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                   8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                   8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                                   8'hAF};
`endif

    function automatic logic [7:0] pix_f(input logic [9:0] k);
        logic [7:0] m;
        m = k[7:0] * 8'd37;
        return m ^ {6'd0, k[9:8]} ^ 8'hC3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Image controller model: registered lookup, one cycle latency.
    always @(posedge clk) bus.pixel_data <= pix_f(bus.byte_counter);
    assign bus2.pixel_data = 8'h5A;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
            busy_prev  = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_prev && bus.tx_valid) begin
                check("stall_tx_data", bus.tx_data, st_data);
                check("stall_tx_dc", bus.tx_dc, st_dc);
                check("stall_byte_counter", bus.byte_counter, st_bc);
            end
            stall_prev = bus.tx_valid && !bus.tx_ready;
            st_data    = bus.tx_data;
            st_dc      = bus.tx_dc;
            st_bc      = bus.byte_counter;
            if (bus.tx_valid && bus.tx_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_byte_sb_size", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("tx_dc", bus.tx_dc, e.dc);
                    check("tx_data", bus.tx_data, e.data);
                    if (e.chk_idx) check("byte_counter", bus.byte_counter, e.idx);
                end
            end
            if (bus.busy && !busy_prev) start_cyc = cyc;
            busy_prev = bus.busy;
            if (bus.frame_done) begin
                check("frame_done_single_cycle", done_prev, 0);
                done_cnt++;
                done_cyc  = cyc;
                done_busy = bus.busy;
            end
            done_prev = bus.frame_done;
        end
        if (!rst2 && bus2.frame_done) done2_cnt++;
    end

    task automatic push_cmd(input logic [7:0] b);
        exp_t e;
        e.dc = 1'b0; e.data = b; e.chk_idx = 1'b0; e.idx = '0;
        sb.push_back(e);
    endtask

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < 6; i++) push_cmd(addr_list[i]);
        for (int k = 0; k < FB; k++) begin
            e.dc = 1'b1; e.data = pix_f(10'(k)); e.chk_idx = 1'b1; e.idx = 10'(k);
            sb.push_back(e);
        end
    endtask

    task automatic req_frames(input int n);
        for (int i = 0; i < n; i++) push_frame();
        bus.frame_req = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        bus.frame_req = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cyc, input bit rnd);
        int n = 0;
        while (done_cnt < target && n < max_cyc) begin
            if (rnd) bus.tx_ready = ($urandom_range(0, 9) < 3);
            @(posedge clk); #1;
            n++;
        end
        bus.tx_ready = 1'b1;
        check("frames_done", done_cnt, target);
    endtask

    task automatic post_reset_checks();
`ifdef OLED_INIT_EN
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        check("init_drained", sb.size(), 0);
        check("init_busy_after", bus.busy, 0);
        check("init_valid_after", bus.tx_valid, 0);
`else
        int quiet = 1;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.tx_valid) quiet = 0;
        end
        check("idle_tx_valid_quiet", quiet, 1);
        check("idle_busy", bus.busy, 0);
`endif
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1; rst2 = 1'b1;
        bus.frame_req = 1'b0;  bus.tx_ready = 1'b0;
        bus2.frame_req = 1'b0; bus2.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_tx_dc", bus.tx_dc, 0);
        check("rst_byte_counter", bus.byte_counter, 0);
        check("rst_frame_done", bus.frame_done, 0);
`ifdef OLED_INIT_EN
        check("rst_busy", bus.busy, 1);
`else
        check("rst_busy", bus.busy, 0);
`endif

        // Short-frame instance: ticks every 100 cycles pile up while stalled.
        rst2 = 1'b0;
        repeat (420) begin @(posedge clk); #1; end
        bus2.tx_ready = 1'b1;
        repeat (65) begin @(posedge clk); #1; end
        check("tick_frames", done2_cnt, 2);
        check("tick_no_chain_busy", bus2.busy, 0);
        rst2 = 1'b1;

`ifdef OLED_INIT_EN
        for (int i = 0; i < 25; i++) push_cmd(init_list[i]);
`endif
        bus.tx_ready = 1'b1;
        rst = 1'b0;
        post_reset_checks();

        base = done_cnt;
        req_frames(1);
        wait_done(base + 1, 4000, 1'b0);
        check("frame_latency", done_cyc - start_cyc, 3078);
        check("busy_at_done", done_busy, 0);
        check("bc_after_frame", bus.byte_counter, 0);
        check("sb_empty_frame1", sb.size(), 0);

        // Second request lands on the IDLE cycle that clears pending.
        base = done_cnt;
        req_frames(2);
        wait_done(base + 2, 30000, 1'b1);
        repeat (20) begin @(posedge clk); #1; end
        check("no_third_frame_busy", bus.busy, 0);
        check("no_third_frame_count", done_cnt, base + 2);
        check("sb_empty_double", sb.size(), 0);

        req_frames(1);
        n = 0;
        while (!(bus.tx_valid && bus.tx_dc && bus.byte_counter == 10'd500) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        bus.tx_ready = 1'b0;
        check("reach_bc500", bus.byte_counter, 500);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_tx_valid", bus.tx_valid, 0);
        check("midrst_byte_counter", bus.byte_counter, 0);
        check("midrst_frame_done", bus.frame_done, 0);
        sb.delete();
`ifdef OLED_INIT_EN
        for (int i = 0; i < 25; i++) push_cmd(init_list[i]);
`endif
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        post_reset_checks();

        base = done_cnt;
        req_frames(1);
        wait_done(base + 1, 4000, 1'b0);
        check("frame_latency_after_rst", done_cyc - start_cyc, 3078);
        check("sb_empty_final", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
